// File: rtl/vga_stream_tx.sv
// vga_stream_tx: free-running VGA raster that aligns a valid/ready pixel stream to frame start
// and drives registered RGB, syncs, data-enable, coordinates, lock and underflow status.
module vga_stream_tx #(
    parameter int   HVA  = 1024,
    parameter int   HFP  = 24,
    parameter int   HSP  = 136,
    parameter int   HBP  = 160,
    parameter int   VVA  = 768,
    parameter int   VFP  = 3,
    parameter int   VSP  = 6,
    parameter int   VBP  = 29,
    parameter logic HPOL = 1'b0,
    parameter logic VPOL = 1'b0,
    parameter int   RD   = 5,
    parameter int   GD   = 6,
    parameter int   BD   = 5,
    parameter int   CW   = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [RD+GD+BD-1:0]   in_data_i,
    input  logic                  in_valid_i,
    input  logic                  in_sof_i,
    output logic                  in_ready_o,
    input  logic                  uf_clr_i,
    output logic [RD-1:0]         r_o,
    output logic [GD-1:0]         g_o,
    output logic [BD-1:0]         b_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic [CW-1:0]         x_o,
    output logic [CW-1:0]         y_o,
    output logic                  locked_o,
    output logic                  underflow_o,
    output logic                  frame_end_o
);
    localparam int DW = RD + GD + BD;
    localparam int HT = HVA + HFP + HSP + HBP;
    localparam int VT = VVA + VFP + VSP + VBP;

    typedef enum logic {HUNT, LOCK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] hc_q, vc_q, hc_d, vc_d, x_q, y_q;
    logic [DW-1:0] pix_q;
    logic          de_q, hs_q, vs_q, fe_q, uf_q;
    logic          h_end, v_end, act, origin, h_sync, v_sync, fire, ok, bad;

    always_comb begin
        h_end      = hc_q == CW'(HT - 1);
        v_end      = vc_q == CW'(VT - 1);
        hc_d       = h_end ? '0 : hc_q + CW'(1);
        vc_d       = h_end ? (v_end ? '0 : vc_q + CW'(1)) : vc_q;
        act        = hc_q < CW'(HVA) && vc_q < CW'(VVA);
        origin     = hc_q == '0 && vc_q == '0;
        h_sync     = hc_q >= CW'(HVA + HFP) && hc_q < CW'(HVA + HFP + HSP);
        v_sync     = vc_q >= CW'(VVA + VFP) && vc_q < CW'(VVA + VFP + VSP);
        // while hunting, non-sof beats drain freely; a sof beat waits for the raster origin
        in_ready_o = rst_ni && (state_q == LOCK ? act : (origin || !in_sof_i));
        fire       = in_valid_i && in_ready_o;
        bad        = state_q == LOCK && fire && (in_sof_i != origin);
        ok         = fire && (state_q == LOCK ? !bad : in_sof_i && origin);
        state_d    = (state_q == HUNT && ok) ? LOCK : bad ? HUNT : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hc_q    <= '0;
            vc_q    <= '0;
            state_q <= HUNT;
            pix_q   <= '0;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~HPOL;
            vs_q    <= ~VPOL;
            fe_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            state_q <= state_d;
            pix_q   <= ok ? in_data_i : '0;
            de_q    <= act;
            x_q     <= hc_q;
            y_q     <= vc_q;
            hs_q    <= h_sync ? HPOL : ~HPOL;
            vs_q    <= v_sync ? VPOL : ~VPOL;
            fe_q    <= h_end && v_end;
            uf_q    <= (state_q == LOCK && act && !in_valid_i) || (uf_q && !uf_clr_i);
        end
    end

    assign r_o         = pix_q[DW-1 -: RD];
    assign g_o         = pix_q[BD +: GD];
    assign b_o         = pix_q[BD-1:0];
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;
    assign de_o        = de_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign locked_o    = state_q == LOCK;
    assign underflow_o = uf_q;
    assign frame_end_o = fe_q;
endmodule

// File: tb/tb_vga_stream_tx.sv
// tb_vga_stream_tx: directed scenarios on a 16x8 raster; a reference model pushes expected
// outputs per driven cycle and they are popped and compared one clock later.
module tb_vga_stream_tx;
    localparam int CW = 12;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0, uf_clr = 1'b0;
    logic [15:0]   in_data = '0;
    logic          rdy, hs, vs, de, locked, uf, fe;
    logic          p_rdy, p_hs, p_vs, p_de, p_locked, p_uf, p_fe;
    logic [4:0]    r, b, p_r, p_b;
    logic [5:0]    g, p_g;
    logic [CW-1:0] x, y, p_x, p_y;

    vga_stream_tx #(.HVA(8), .HFP(2), .HSP(3), .HBP(3), .VVA(4), .VFP(1), .VSP(2), .VBP(1),
                    .HPOL(1'b0), .VPOL(1'b0), .CW(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_sof_i(in_sof), .in_ready_o(rdy), .uf_clr_i(uf_clr), .r_o(r), .g_o(g), .b_o(b),
        .hsync_o(hs), .vsync_o(vs), .de_o(de), .x_o(x), .y_o(y), .locked_o(locked),
        .underflow_o(uf), .frame_end_o(fe));

    vga_stream_tx #(.HVA(8), .HFP(2), .HSP(3), .HBP(3), .VVA(4), .VFP(1), .VSP(2), .VBP(1),
                    .HPOL(1'b1), .VPOL(1'b1), .CW(CW)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_sof_i(in_sof), .in_ready_o(p_rdy), .uf_clr_i(uf_clr), .r_o(p_r), .g_o(p_g), .b_o(p_b),
        .hsync_o(p_hs), .vsync_o(p_vs), .de_o(p_de), .x_o(p_x), .y_o(p_y), .locked_o(p_locked),
        .underflow_o(p_uf), .frame_end_o(p_fe));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   rgb;
        logic          de;
        logic [CW-1:0] x, y;
        logic          hs, vs, fe, locked, uf;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0;
    int   m_hc = 0, m_vc = 0, bi = 0, de_cnt = 0, fe_cnt = 0;
    bit   m_lock = 0, m_uf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] pix(input int n);
        return 16'(n * 37 + 16'h0A05);
    endfunction

    task automatic step(input logic rr, input logic v, input logic s, input logic [15:0] d,
                        input logic clr, output bit fired);
        exp_t e;
        bit origin, act, exp_rdy, ok, bad, nl, uf_set;
        rst_n = rr; in_valid = v; in_sof = s; in_data = d; uf_clr = clr;
        origin  = m_hc == 0 && m_vc == 0;
        act     = m_hc < 8 && m_vc < 4;
        exp_rdy = rr && (m_lock ? act : (origin || !s));
        fired   = v && exp_rdy;
        ok      = fired && (m_lock ? (s == origin) : (s && origin));
        bad     = m_lock && fired && (s != origin);
        nl      = m_lock ? !bad : ok;
        uf_set  = m_lock && act && !v;
        #1;
        chk("in_ready", rdy, exp_rdy);
        chk("p_in_ready", p_rdy, exp_rdy);
        e.rgb    = (rr && ok) ? d : 16'h0;
        e.de     = rr && act;
        e.x      = rr ? CW'(m_hc) : '0;
        e.y      = rr ? CW'(m_vc) : '0;
        e.hs     = !rr || !(m_hc >= 10 && m_hc < 13);
        e.vs     = !rr || !(m_vc >= 5 && m_vc < 7);
        e.fe     = rr && m_hc == 15 && m_vc == 7;
        e.locked = rr && nl;
        e.uf     = rr && (uf_set || (m_uf && !clr));
        sbq.push_back(e);
        if (!rr) begin
            m_hc = 0; m_vc = 0; m_lock = 0; m_uf = 0;
        end else begin
            m_lock = nl;
            m_uf   = e.uf;
            if (m_hc == 15) begin
                m_hc = 0;
                m_vc = (m_vc == 7) ? 0 : m_vc + 1;
            end else m_hc++;
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("rgb", {r, g, b}, e.rgb);
        chk("de", de, e.de);
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("hsync", hs, e.hs);
        chk("vsync", vs, e.vs);
        chk("frame_end", fe, e.fe);
        chk("locked", locked, e.locked);
        chk("underflow", uf, e.uf);
        chk("p_rgb", {p_r, p_g, p_b}, e.rgb);
        chk("p_hsync", p_hs, !e.hs);
        chk("p_vsync", p_vs, !e.vs);
        chk("p_de_xy", {p_de, p_x, p_y}, {e.de, e.x, e.y});
        chk("p_status", {p_locked, p_uf, p_fe}, {e.locked, e.uf, e.fe});
        if (de) de_cnt++;
        if (fe) fe_cnt++;
    endtask

    task automatic stream(input int n);
        bit f;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, bi % 32 == 0, pix(bi), 1'b0, f);
            if (f) bi++;
        end
    endtask

    task automatic go_to(input int h, input int v);
        int k = 0;
        while (!(m_hc == h && m_vc == v) && k < 300) begin
            stream(1);
            k++;
        end
        chk("reach_position", k < 300, 1);
    endtask

    initial begin
        bit f;
        int k;
        // power-up reset and free-running always-valid stream
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, f);
        de_cnt = 0; fe_cnt = 0;
        stream(384);
        chk("de_count_3_frames", de_cnt, 96);
        chk("frame_end_count", fe_cnt, 3);
        chk("locked_stream", locked, 1);
        // reset held 3 clocks mid-frame
        go_to(6, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, f);
        chk("rst_sync", {hs, vs, de, locked, uf}, 5'b11000);
        // hunt: five non-sof beats dropped, sof held until the origin
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, f);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h1111 * i[15:0], 1'b0, f);
            chk("hunt_drop", rdy, 1);
        end
        f = 0; k = 0;
        while (!f && k < 200) begin
            step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, f);
            k++;
        end
        chk("sof_consumed", f, 1);
        chk("sof_pixel", {r, g, b}, 16'h1234);
        chk("sof_xy", {x, y}, 24'h0);
        chk("sof_locked", locked, 1);
        bi = 1;
        // underflow at (3,1), sticky until cleared
        go_to(3, 1);
        step(1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, f);
        bi++;
        chk("uf_pixel", {r, g, b, de, uf, locked}, {16'h0, 3'b111});
        k = bi;
        step(1'b1, 1'b1, 1'b0, pix(k), 1'b0, f);
        bi++;
        chk("after_uf_pixel", {r, g, b}, pix(k));
        stream(5);
        chk("uf_sticky", uf, 1);
        step(1'b1, 1'b1, bi % 32 == 0, pix(bi), 1'b1, f);
        if (f) bi++;
        chk("uf_cleared", uf, 0);
        // stray sof at (4,2) drops lock, relock at next origin
        go_to(4, 2);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, f);
        chk("stray_sof", {r, g, b, locked}, 17'h0);
        k = 0;
        while (!locked && k < 300) begin
            stream(1);
            k++;
        end
        chk("relock", locked, 1);
        chk("relock_xy", {x, y}, 24'h0);
        // one-clock reset at (5,1)
        go_to(5, 1);
        step(1'b0, 1'b1, 1'b0, 16'hABCD, 1'b0, f);
        chk("rst1_out", {r, g, b, de, hs, vs, locked, x}, {16'h0, 4'b0110, 12'h0});
        stream(1);
        chk("post_rst_origin", {x, y, locked}, 25'h0);
        k = 0;
        while (!locked && k < 300) begin
            stream(1);
            k++;
        end
        chk("relock_after_rst", locked, 1);
        stream(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
